// File: rtl/cache_rd_arbiter.sv
// cache_rd_arbiter: shares the single memory read channel between the ICache
// and DCache miss/uncached paths. One read transaction is in flight at a time:
// arbitrate in IDLE, present the address in ADDR, route returned beats in DATA.
//
// Handshakes: a transfer happens on any cycle where valid and ready are both
// high (mem_ar_valid/mem_ar_ready for the address phase, mem_r_valid/mem_r_ready
// for data beats). Once valid is raised its payload stays stable until the
// transfer; ready may be driven independently of valid.
module cache_rd_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int BURST_LEN    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ic_req,
    input  logic                  ic_burst,
    input  logic [31:0]           ic_addr,
    output logic                  ic_gnt,
    output logic                  ic_rvalid,
    output logic                  ic_rlast,
    input  logic                  dc_req,
    input  logic                  dc_burst,
    input  logic [31:0]           dc_addr,
    output logic                  dc_gnt,
    output logic                  dc_rvalid,
    output logic                  dc_rlast,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_ar_valid,
    input  logic                  mem_ar_ready,
    output logic [31:0]           mem_ar_addr,
    output logic [3:0]            mem_ar_len,
    input  logic                  mem_r_valid,
    output logic                  mem_r_ready,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    input  logic                  mem_r_last,
    output logic                  prot_err,
    output logic [1:0]            dbg_state
);

    // Line size in bytes is BURST_LEN words; bursts are aligned to it.
    localparam logic [31:0] LINE_MASK   = ~(32'(BURST_LEN * 4) - 32'd1);
    localparam logic [3:0]  BURST_ARLEN = 4'(BURST_LEN - 1);
    localparam int          SW          = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                state;
    logic                  owner_ic;
    logic [3:0]            beat_cnt;
    logic [SW-1:0]         starve_cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  prot_err_q;

    logic                  ic_wins;
    logic                  sel_burst;
    logic [31:0]           sel_addr;
    logic [31:0]           next_addr;
    logic [3:0]            next_len;
    logic                  ar_fire;
    logic                  beat;
    logic                  last_beat;

    // Arbitration: DCache first, unless the ICache has been passed over
    // STARVE_LIMIT times in a row; then pick the winner's address and length.
    always_comb begin
        ic_wins   = ic_req && (!dc_req || (starve_cnt == STARVE_MAX));
        sel_addr  = ic_wins ? ic_addr  : dc_addr;
        sel_burst = ic_wins ? ic_burst : dc_burst;
        next_addr = sel_burst ? (sel_addr & LINE_MASK) : sel_addr;
        next_len  = sel_burst ? BURST_ARLEN : 4'd0;
    end

    assign ar_fire   = (state == S_ADDR) && mem_ar_ready;
    assign beat      = (state == S_DATA) && mem_r_valid;
    assign last_beat = (beat_cnt == 4'd0);

    // Transaction FSM plus latched address phase, beat counter, starvation
    // counter, held read data and the sticky burst-length error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            owner_ic    <= 1'b0;
            beat_cnt    <= 4'd0;
            starve_cnt  <= '0;
            mem_ar_addr <= 32'd0;
            mem_ar_len  <= 4'd0;
            rdata_q     <= '0;
            prot_err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ic_req || dc_req) begin
                        owner_ic    <= ic_wins;
                        mem_ar_addr <= next_addr;
                        mem_ar_len  <= next_len;
                        state       <= S_ADDR;
                    end
                    if (ic_wins || !ic_req) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != STARVE_MAX) begin
                        starve_cnt <= starve_cnt + SW'(1);
                    end
                end
                S_ADDR: begin
                    if (mem_ar_ready) begin
                        beat_cnt <= mem_ar_len;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (mem_r_valid) begin
                        rdata_q <= mem_r_data;
                        if (mem_r_last != last_beat) begin
                            prot_err_q <= 1'b1;
                        end
                        // Our own count ends the burst, not memory's last flag.
                        if (last_beat) begin
                            state <= S_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt - 4'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ic_gnt       = ar_fire && owner_ic;
    assign dc_gnt       = ar_fire && !owner_ic;
    assign ic_rvalid    = beat && owner_ic;
    assign dc_rvalid    = beat && !owner_ic;
    assign ic_rlast     = beat && owner_ic && last_beat;
    assign dc_rlast     = beat && !owner_ic && last_beat;
    assign rdata        = beat ? mem_r_data : rdata_q;
    assign mem_ar_valid = (state == S_ADDR);
    assign mem_r_ready  = (state == S_DATA);
    assign prot_err     = prot_err_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Testbench for cache_rd_arbiter: directed request sequences, a bench-side
// memory responder, and a transaction-level model checked every cycle.
module tb_cache_rd_arbiter;

    localparam int BL = 4;

    logic        clk;
    logic        reset;
    logic        ic_req, ic_burst, dc_req, dc_burst;
    logic [31:0] ic_addr, dc_addr;
    logic        ic_gnt, ic_rvalid, ic_rlast, dc_gnt, dc_rvalid, dc_rlast;
    logic [31:0] rdata;
    logic        mem_ar_valid, mem_ar_ready;
    logic [31:0] mem_ar_addr;
    logic [3:0]  mem_ar_len;
    logic        mem_r_valid, mem_r_ready, mem_r_last;
    logic [31:0] mem_r_data;
    logic        prot_err;
    logic [1:0]  dbg_state;

    cache_rd_arbiter #(.DATA_WIDTH(32), .BURST_LEN(BL), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_burst(ic_burst), .ic_addr(ic_addr),
        .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast),
        .dc_req(dc_req), .dc_burst(dc_burst), .dc_addr(dc_addr),
        .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rlast(dc_rlast),
        .rdata(rdata),
        .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready),
        .mem_ar_addr(mem_ar_addr), .mem_ar_len(mem_ar_len),
        .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready),
        .mem_r_data(mem_r_data), .mem_r_last(mem_r_last),
        .prot_err(prot_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at 400000, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    // Expected address phases in issue order: {owner_is_ic, len, addr}.
    logic [36:0] exp_q[$];
    int          m_left  = 0;       // beats still owed for the open transaction
    logic        m_owner = 1'b0;    // 1 = ICache owns the open transaction
    logic        m_perr  = 1'b0;
    logic [31:0] m_rdata = 32'd0;

    int ic_beats = 0, dc_beats = 0, ic_lasts = 0, dc_lasts = 0;
    int ic_gnts = 0, dc_gnts = 0;
    int last_rlast_cyc = 0;
    logic [31:0] last_rlast_data = 32'd0;

    // Memory responder controls.
    logic        ar_ready_en = 1'b0;
    logic [31:0] data_base   = 32'd0;
    int          bad_last_idx = -1;
    int          mem_left = 0;
    int          beat_idx = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Spec-level expected address phase for a request.
    function automatic logic [36:0] mk(input logic ic, input logic [31:0] a, input logic burst);
        logic [31:0] line_bytes;
        line_bytes = 32'(BL * 4);
        if (burst) return {ic, 4'(BL - 1), a - (a % line_bytes)};
        return {ic, 4'd0, a};
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        mem_ar_ready = 1'b0; mem_r_valid = 1'b0; mem_r_data = 32'd0; mem_r_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mem_left = 0;
                beat_idx = 0;
            end else if (mem_ar_valid && mem_ar_ready) begin
                mem_left = int'(mem_ar_len) + 1;
                beat_idx = 0;
            end else if (mem_r_valid && mem_r_ready) begin
                mem_left--;
                beat_idx++;
            end
            @(posedge clk);
            #1;
            mem_ar_ready = ar_ready_en;
            mem_r_valid  = (mem_left > 0);
            mem_r_data   = data_base + 32'(beat_idx);
            mem_r_last   = (mem_left == 1) ^ (beat_idx == bad_last_idx);
        end
    end

    // ---------------- compare process ----------------
    initial begin
        logic [36:0] t;
        logic hs, bt, e_ic, e_dc, popped;
        int new_left;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_ctrl", 64'({ic_gnt, dc_gnt, ic_rvalid, dc_rvalid, ic_rlast, dc_rlast,
                                     mem_ar_valid, mem_r_ready, prot_err, dbg_state, mem_ar_len}), 64'(0));
                chk("rst_data", 64'({rdata, mem_ar_addr}), 64'(0));
                exp_q.delete();
                m_left = 0; m_perr = 1'b0; m_rdata = 32'd0;
            end else begin
                hs = mem_ar_valid && mem_ar_ready;
                bt = mem_r_valid && (m_left > 0);
                e_ic = 1'b0; e_dc = 1'b0; popped = 1'b0; new_left = 0;
                chk("ar_in_data", 64'(mem_ar_valid && (m_left != 0)), 64'(0));
                chk("ar_unexpected", 64'(mem_ar_valid && (exp_q.size() == 0)), 64'(0));
                if (mem_ar_valid && exp_q.size() != 0) begin
                    t = exp_q[0];
                    chk("ar_addr", 64'(mem_ar_addr), 64'(t[31:0]));
                    chk("ar_len", 64'(mem_ar_len), 64'(t[35:32]));
                    if (hs) begin
                        e_ic = t[36];
                        e_dc = !t[36];
                        void'(exp_q.pop_front());
                        popped = 1'b1;
                        new_left = int'(t[35:32]) + 1;
                    end
                end
                chk("ic_gnt", 64'(ic_gnt), 64'(e_ic));
                chk("dc_gnt", 64'(dc_gnt), 64'(e_dc));
                chk("r_ready", 64'(mem_r_ready), 64'(m_left > 0));
                chk("ic_rvalid", 64'(ic_rvalid), 64'(bt && m_owner));
                chk("dc_rvalid", 64'(dc_rvalid), 64'(bt && !m_owner));
                chk("ic_rlast", 64'(ic_rlast), 64'(bt && m_owner && (m_left == 1)));
                chk("dc_rlast", 64'(dc_rlast), 64'(bt && !m_owner && (m_left == 1)));
                chk("rdata", 64'(rdata), 64'(bt ? mem_r_data : m_rdata));
                chk("prot_err", 64'(prot_err), 64'(m_perr));
                if (ic_rvalid) ic_beats++;
                if (dc_rvalid) dc_beats++;
                if (ic_rlast) ic_lasts++;
                if (dc_rlast) dc_lasts++;
                if (ic_gnt) ic_gnts++;
                if (dc_gnt) dc_gnts++;
                if (ic_rlast || dc_rlast) begin
                    last_rlast_cyc  = cyc;
                    last_rlast_data = rdata;
                end
                if (bt) begin
                    m_rdata = mem_r_data;
                    if (mem_r_last != (m_left == 1)) m_perr = 1'b1;
                    m_left--;
                end
                if (popped) begin
                    m_owner = e_ic;
                    m_left  = new_left;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Raise a request, hold it until its grant, drop it the cycle after.
    task automatic req_one(input logic is_ic, input logic [31:0] a, input logic burst,
                           output int lat, output int gnt_cyc);
        int start;
        start = cyc;
        gnt_cyc = -1;
        if (is_ic) begin ic_req = 1'b1; ic_addr = a; ic_burst = burst; end
        else       begin dc_req = 1'b1; dc_addr = a; dc_burst = burst; end
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (is_ic ? ic_gnt : dc_gnt) begin
                gnt_cyc = cyc;
                break;
            end
        end
        if (gnt_cyc < 0) begin
            n_checks++; n_errors++;
            $display("FAIL gnt_timeout: got no grant for 0x%0h in 600 cycles, required one", a);
        end
        lat = gnt_cyc - start;
        @(posedge clk);
        #1;
        if (is_ic) ic_req = 1'b0;
        else       dc_req = 1'b0;
    endtask

    // Keep dc_req asserted across n grants.
    task automatic hold_dc(input logic [31:0] a, input logic burst, input int n);
        int got;
        got = 0;
        dc_req = 1'b1; dc_addr = a; dc_burst = burst;
        for (int i = 0; i < 800 && got < n; i++) begin
            @(negedge clk);
            if (dc_gnt) got++;
        end
        if (got < n) begin
            n_checks++; n_errors++;
            $display("FAIL hold_dc_timeout: got %0d grants, required %0d", got, n);
        end
        @(posedge clk);
        #1;
        dc_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && m_left == 0 && !mem_ar_valid && dbg_state == 2'd0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL %s: got no return to idle in 300 cycles, required idle", name);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int lat, g, g1, g2, gi, gd, rl, lat1, lat2, b0, b1, b2, b3, dc_before;
        reset = 1'b0;
        ic_req = 1'b0; ic_burst = 1'b0; ic_addr = 32'd0;
        dc_req = 1'b0; dc_burst = 1'b0; dc_addr = 32'd0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // Single DCache burst with a stalled address phase.
        data_base = 32'hA;
        b0 = dc_beats; b1 = ic_beats; b2 = dc_lasts; b3 = dc_gnts;
        exp_q.push_back({1'b0, 4'd3, 32'h1FC0_0A10});
        fork
            req_one(1'b0, 32'h1FC0_0A14, 1'b1, lat, g);
            begin
                repeat (3) @(posedge clk);
                #2 ar_ready_en = 1'b1;
            end
        join
        wait_idle("t1_idle");
        chk("t1_dc_beats", 64'(dc_beats - b0), 64'(4));
        chk("t1_ic_beats", 64'(ic_beats - b1), 64'(0));
        chk("t1_dc_rlast_cnt", 64'(dc_lasts - b2), 64'(1));
        chk("t1_dc_gnt_cnt", 64'(dc_gnts - b3), 64'(1));
        chk("t1_rlast_data", 64'(last_rlast_data), 64'(32'hD));
        chk("t1_rdata_hold", 64'(rdata), 64'(32'hD));
        chk("t1_state_idle", 64'(dbg_state), 64'(0));

        // Back-to-back bursts with zero-wait memory.
        data_base = 32'h100;
        exp_q.push_back(mk(1'b0, 32'h0000_1234, 1'b1));
        exp_q.push_back(mk(1'b0, 32'h0000_2000, 1'b1));
        req_one(1'b0, 32'h0000_1234, 1'b1, lat1, g1);
        req_one(1'b0, 32'h0000_2000, 1'b1, lat2, g2);
        rl = last_rlast_cyc;
        wait_idle("t2_idle");
        chk("t2_req_to_ar", 64'(lat1), 64'(1));
        chk("t2_ar_to_ar", 64'(g2 - g1), 64'(6));
        chk("t2_last_to_ar", 64'(g2 - rl), 64'(2));
        chk("t2_first_addr_model", 64'(mk(1'b0, 32'h0000_1234, 1'b1)), 64'({1'b0, 4'd3, 32'h0000_1230}));

        // Simultaneous single requests: DCache first.
        data_base = 32'h200;
        b0 = ic_gnts; b1 = dc_gnts;
        exp_q.push_back(mk(1'b0, 32'h0000_4004, 1'b0));
        exp_q.push_back(mk(1'b1, 32'h0000_8008, 1'b0));
        fork
            req_one(1'b1, 32'h0000_8008, 1'b0, lat, gi);
            req_one(1'b0, 32'h0000_4004, 1'b0, lat1, gd);
        join
        wait_idle("t3_idle");
        chk("t3_order_gap", 64'(gi - gd), 64'(3));
        chk("t3_ic_gnt_cnt", 64'(ic_gnts - b0), 64'(1));
        chk("t3_dc_gnt_cnt", 64'(dc_gnts - b1), 64'(1));

        // Starvation: eight DCache wins, then the ICache.
        data_base = 32'h300;
        b0 = dc_gnts;
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(1'b0, 32'h0000_5000, 1'b0));
        exp_q.push_back(mk(1'b1, 32'h0000_6000, 1'b0));
        exp_q.push_back(mk(1'b0, 32'h0000_5000, 1'b0));
        fork
            hold_dc(32'h0000_5000, 1'b0, 9);
            begin
                req_one(1'b1, 32'h0000_6000, 1'b0, lat, gi);
                dc_before = dc_gnts - b0;
            end
        join
        wait_idle("t4_idle");
        chk("t4_dc_before_ic", 64'(dc_before), 64'(8));
        chk("t4_dc_total", 64'(dc_gnts - b0), 64'(9));

        // Flush: ICache drops req after gnt, beats still delivered.
        data_base = 32'h400;
        b0 = ic_beats; b1 = ic_lasts; b2 = dc_beats;
        exp_q.push_back(mk(1'b1, 32'h0000_9ABC, 1'b1));
        req_one(1'b1, 32'h0000_9ABC, 1'b1, lat, g);
        wait_idle("t5_idle");
        chk("t5_ic_beats", 64'(ic_beats - b0), 64'(4));
        chk("t5_ic_rlast_cnt", 64'(ic_lasts - b1), 64'(1));
        chk("t5_dc_beats", 64'(dc_beats - b2), 64'(0));
        chk("t5_state_idle", 64'(dbg_state), 64'(0));

        // Protocol error: memory flags last on beat 2 of 4.
        chk("t6_perr_before", 64'(prot_err), 64'(0));
        data_base = 32'h500;
        bad_last_idx = 1;
        b0 = dc_beats; b1 = dc_lasts;
        exp_q.push_back(mk(1'b0, 32'h0000_A010, 1'b1));
        req_one(1'b0, 32'h0000_A010, 1'b1, lat, g);
        wait_idle("t6_idle");
        bad_last_idx = -1;
        chk("t6_perr_set", 64'(prot_err), 64'(1));
        chk("t6_dc_beats", 64'(dc_beats - b0), 64'(4));
        chk("t6_dc_rlast_cnt", 64'(dc_lasts - b1), 64'(1));
        exp_q.push_back(mk(1'b1, 32'h0000_B000, 1'b0));
        req_one(1'b1, 32'h0000_B000, 1'b0, lat, g);
        wait_idle("t6_idle2");
        chk("t6_perr_sticky", 64'(prot_err), 64'(1));

        // Reset mid-burst, after beat 2.
        data_base = 32'h600;
        b0 = dc_beats;
        exp_q.push_back(mk(1'b0, 32'h0000_C000, 1'b1));
        req_one(1'b0, 32'h0000_C000, 1'b1, lat, g);
        b1 = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (dc_beats - b0 >= 2) begin
                b1 = 1;
                break;
            end
        end
        if (b1 == 0) begin
            n_checks++; n_errors++;
            $display("FAIL t7_beats_timeout: got %0d beats, required 2", dc_beats - b0);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("t7_async_ctrl", 64'({dc_rvalid, dc_rlast, mem_r_ready, mem_ar_valid, prot_err, dbg_state}), 64'(0));
        chk("t7_async_rdata", 64'(rdata), 64'(0));
        chk("t7_async_addr", 64'({mem_ar_addr, mem_ar_len}), 64'(0));
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(mk(1'b0, 32'h0000_D004, 1'b0));
        req_one(1'b0, 32'h0000_D004, 1'b0, lat, g);
        wait_idle("t7_idle");
        chk("t7_req_to_ar", 64'(lat), 64'(1));
        chk("t7_perr_cleared", 64'(prot_err), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
